zebra_stripe_analyzer: RTL and testbench
========================================

ZEBRA_STRIPE_ANALYZER -- requirements
Module: zebra_stripe_analyzer

Interface
- REQ-001: Parameters (name, default, meaning):
  - IMG_WIDTH 640: pixels per row.
  - IMG_HEIGHT 480: rows per frame.
  - W 8: pixel width.
  - NUM_BANDS 4: horizontal row bands; SHALL divide IMG_HEIGHT.
  - MIN_STRIPE_W 8: minimum white-run length counted as a stripe.
  - MAX_STRIPE_W 120: maximum white-run length counted as a stripe.
  - MIN_STRIPES 4: stripes needed for a row to qualify.
  - ROW_QUAL_MIN 60: qualifying rows needed for a band to qualify.
  - MIN_BANDS 2: qualifying bands needed for a frame to be positive.
  - HYST_FRAMES 3: consecutive frames needed to toggle the decision.
- REQ-002: Ports (name, direction, width, meaning):
  - clk, in, 1: single clock.
  - rst_n, in, 1: asynchronous active-low reset.
  - x_valid, in, 1: pixel valid.
  - x_ready, out, 1: pixel ready.
  - x_data, in, W: edge-filtered pixel, raster order.
  - cfg_thresh, in, W: binarisation threshold.
  - crossing_detected, out, 1: hysteresis-filtered decision.
  - detection_valid, out, 1: one-cycle pulse per frame.
  - stripe_count, out, 8: maximum per-row stripe count of the last frame.
  - band_mask, out, NUM_BANDS: qualifying bands of the last frame; bit 0 is the top band.

Function
- REQ-003: A pixel SHALL be consumed only on a cycle where x_valid && x_ready; column and row counters SHALL advance only on consumption.
- REQ-004: A pixel SHALL be white iff x_data >= the threshold latched from cfg_thresh on the first pixel of the frame; mid-frame cfg_thresh changes SHALL be ignored until the next frame.
- REQ-005: Run tracking:
  - A white run SHALL count as a stripe iff MIN_STRIPE_W <= length <= MAX_STRIPE_W.
  - A run SHALL close on a black pixel or at column IMG_WIDTH-1.
  - Runs SHALL NOT span rows.
- REQ-006: The run-length counter SHALL saturate at MAX_STRIPE_W+1, so over-long runs never qualify.
- REQ-007: The per-row stripe counter SHALL saturate at 255 and reset to 0 at each row start.
- REQ-008: At each row end, the row SHALL qualify iff stripes >= MIN_STRIPES; the band row-qualify counter SHALL then increment.
- REQ-009: At each band's last row, the band bit SHALL be set iff its qualify count >= ROW_QUAL_MIN; the counter SHALL then clear.
- REQ-010: FSM states are RUN and DECIDE.
  - RUN: x_ready=1.
  - On consumption of pixel (IMG_WIDTH-1, IMG_HEIGHT-1), the FSM SHALL enter DECIDE.
  - DECIDE: x_ready=0 for exactly one cycle, then return to RUN.
- REQ-011: In DECIDE, the block SHALL update band_mask and stripe_count, and evaluate the frame as positive iff popcount(band_mask) >= MIN_BANDS.
- REQ-012: detection_valid SHALL pulse high on the cycle after DECIDE, coincident with the first cycle outputs show the new values; outputs SHALL hold until the next DECIDE.
- REQ-013: Hysteresis:
  - A streak counter SHALL count consecutive frames whose positive result differs from crossing_detected; a frame agreeing with crossing_detected SHALL clear it.
  - When the streak reaches HYST_FRAMES, crossing_detected SHALL toggle and the streak SHALL clear.
- REQ-014: With HYST_FRAMES=1, crossing_detected SHALL follow each frame result with no extra latency beyond REQ-012.
- REQ-015: x_valid low mid-row SHALL stall all counters without ending runs.

Reset
- REQ-016: On rst_n low, asynchronously:
  - FSM SHALL enter RUN; all counters and the streak SHALL clear.
  - Outputs SHALL be: crossing_detected=0, detection_valid=0, stripe_count=0, band_mask=0, x_ready=0.
- REQ-017: x_ready SHALL rise on the first clk edge after rst_n deasserts.
- REQ-018: Reset mid-frame SHALL discard the partial frame; the next consumed pixel SHALL be treated as (0,0).

Structure
- REQ-019: Package zebra_pkg SHALL hold the FSM state enum and a function for saturating count width, $clog2(MAX_STRIPE_W+2).
- REQ-020: Sub-module zebra_row_runlength SHALL hold the run/stripe counters for one row.
- REQ-021: The parent SHALL own band accumulation, the FSM, and hysteresis.
- REQ-022: The block SHALL be a drop-in successor downstream of convolution_filter, with its y_valid/y_ready/y_data driving x_valid/x_ready/x_data.

Verification
All scenarios use IMG_WIDTH=32, IMG_HEIGHT=8, NUM_BANDS=2, MIN_STRIPE_W=2, MAX_STRIPE_W=6, MIN_STRIPES=3, ROW_QUAL_MIN=3, MIN_BANDS=2, HYST_FRAMES=2, cfg_thresh=128.
- REQ-023: Every row = 4x(4 white@255, 4 black@0):
  - Frame 1: detection_valid pulse, stripe_count=4, band_mask=2'b11, crossing_detected=0.
  - Frame 2: crossing_detected=1.
- REQ-024: Rows all white (run of 32 > MAX_STRIPE_W): stripe_count=0, band_mask=0; after 2 such frames following REQ-023, crossing_detected=0.
- REQ-025: Row ending in a 3-white run at columns 29-31 plus 2 interior stripes: stripes=3, so the row qualifies (edge-closed run counted).
- REQ-026: Alternating positive/negative frames starting from crossing_detected=0: crossing_detected stays 0 (streak clears).
- REQ-027: Random x_valid gaps during the REQ-023 stimulus give identical outputs; x_ready=0 exactly one cycle per frame.
- REQ-028: rst_n pulsed at row 5, then a full REQ-023 frame: outputs match a clean first frame.

Source files
------------

// File: rtl/zebra_pkg.sv
// Shared types and sizing helpers for the zebra crossing stripe analyzer.
// Holds the FSM state enum and counter-width functions; no ports.
package zebra_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_DECIDE = 1'b1
    } state_t;

    // Bits for a run counter that saturates one past the longest stripe.
    function automatic int sat_cnt_w(input int max_w);
        return $clog2(max_w + 2);
    endfunction

    // Bits to index n items (at least one bit).
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/zebra_row_runlength.sv
// Per-row white-run tracker: measures runs and counts stripe-length runs.
// Ports: clk, rst_n, take (pixel consumed), white, last_col,
//        row_stripes (row total including a run closed by this pixel).
module zebra_row_runlength
    import zebra_pkg::*;
#(
    parameter int MIN_STRIPE_W = 8,
    parameter int MAX_STRIPE_W = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       take,
    input  logic       white,
    input  logic       last_col,
    output logic [7:0] row_stripes
);

    localparam int RW = sat_cnt_w(MAX_STRIPE_W);
    localparam logic [RW-1:0] RUN_SAT = RW'(MAX_STRIPE_W + 1);
    localparam logic [RW-1:0] LEN_MIN = RW'(MIN_STRIPE_W);
    localparam logic [RW-1:0] LEN_MAX = RW'(MAX_STRIPE_W);

    logic [RW-1:0] run_len;
    logic [RW-1:0] len_inc;
    logic [RW-1:0] close_len;
    logic [7:0]    stripes;
    logic          hit;

    // A run closes on a black pixel or at the row edge; an edge-closed
    // run includes the final white pixel.
    always_comb begin
        len_inc     = (run_len == RUN_SAT) ? RUN_SAT : run_len + RW'(1);
        close_len   = white ? len_inc : run_len;
        hit         = (!white || last_col)
                      && (close_len >= LEN_MIN)
                      && (close_len <= LEN_MAX);
        row_stripes = (hit && stripes != 8'hFF) ? stripes + 8'd1 : stripes;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len <= '0;
            stripes <= '0;
        end else if (take) begin
            if (last_col) begin
                run_len <= '0;
                stripes <= '0;
            end else if (white) begin
                run_len <= len_inc;
            end else begin
                run_len <= '0;
                stripes <= row_stripes;
            end
        end
    end

endmodule

// File: rtl/zebra_stripe_analyzer.sv
// Zebra crossing detector on a raster pixel stream with frame hysteresis.
// Ports: clk, rst_n, x_valid/x_ready/x_data stream in, cfg_thresh,
//        crossing_detected, detection_valid, stripe_count, band_mask.
module zebra_stripe_analyzer
    import zebra_pkg::*;
#(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int W            = 8,
    parameter int NUM_BANDS    = 4,
    parameter int MIN_STRIPE_W = 8,
    parameter int MAX_STRIPE_W = 120,
    parameter int MIN_STRIPES  = 4,
    parameter int ROW_QUAL_MIN = 60,
    parameter int MIN_BANDS    = 2,
    parameter int HYST_FRAMES  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [W-1:0]         x_data,
    input  logic [W-1:0]         cfg_thresh,
    output logic                 crossing_detected,
    output logic                 detection_valid,
    output logic [7:0]           stripe_count,
    output logic [NUM_BANDS-1:0] band_mask
);

    localparam int ROWS_PB = IMG_HEIGHT / NUM_BANDS;
    localparam int CW  = bits_for(IMG_WIDTH);
    localparam int RBW = bits_for(ROWS_PB);
    localparam int BW  = bits_for(NUM_BANDS);
    localparam int QW  = bits_for(max_int(ROWS_PB, ROW_QUAL_MIN) + 1);
    localparam int HW  = bits_for(HYST_FRAMES + 1);

    localparam logic [CW-1:0]  LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [RBW-1:0] LAST_RIB  = RBW'(ROWS_PB - 1);
    localparam logic [BW-1:0]  LAST_BAND = BW'(NUM_BANDS - 1);
    localparam logic [QW-1:0]  QUAL_MIN  = QW'(ROW_QUAL_MIN);
    localparam logic [7:0]     STR_MIN   = 8'(MIN_STRIPES);
    localparam logic [HW-1:0]  HYST_LAST = HW'(HYST_FRAMES - 1);

    state_t               state;
    logic [CW-1:0]        col;
    logic [RBW-1:0]       rib;
    logic [BW-1:0]        band;
    logic [W-1:0]         thr_q;
    logic [QW-1:0]        qual_cnt;
    logic [NUM_BANDS-1:0] band_acc;
    logic [7:0]           frame_max;
    logic [HW-1:0]        streak;

    logic          take;
    logic          first_px;
    logic [W-1:0]  thr;
    logic          white;
    logic          last_col;
    logic          row_end;
    logic          band_end;
    logic          frame_end;
    logic [7:0]    row_total;
    logic          row_ok;
    logic [QW-1:0] q_next;
    logic          pos;

    // The first pixel uses cfg_thresh directly; the rest of the frame
    // uses the copy latched on that pixel.
    always_comb begin
        take      = x_valid && x_ready;
        first_px  = (col == '0) && (rib == '0) && (band == '0);
        thr       = first_px ? cfg_thresh : thr_q;
        white     = (x_data >= thr);
        last_col  = (col == LAST_COL);
        row_end   = take && last_col;
        band_end  = row_end && (rib == LAST_RIB);
        frame_end = band_end && (band == LAST_BAND);
        row_ok    = (row_total >= STR_MIN);
        q_next    = qual_cnt + QW'(row_ok);
        pos       = ($countones(band_acc) >= MIN_BANDS);
    end

    zebra_row_runlength #(
        .MIN_STRIPE_W (MIN_STRIPE_W),
        .MAX_STRIPE_W (MAX_STRIPE_W)
    ) u_row (
        .clk         (clk),
        .rst_n       (rst_n),
        .take        (take),
        .white       (white),
        .last_col    (last_col),
        .row_stripes (row_total)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_RUN;
            x_ready           <= 1'b0;
            col               <= '0;
            rib               <= '0;
            band              <= '0;
            thr_q             <= '0;
            qual_cnt          <= '0;
            band_acc          <= '0;
            frame_max         <= '0;
            streak            <= '0;
            crossing_detected <= 1'b0;
            detection_valid   <= 1'b0;
            stripe_count      <= '0;
            band_mask         <= '0;
        end else begin
            detection_valid <= 1'b0;
            case (state)
                ST_RUN: begin
                    x_ready <= 1'b1;
                    if (take) begin
                        if (first_px) thr_q <= cfg_thresh;
                        col <= last_col ? '0 : col + CW'(1);
                        if (row_end) begin
                            if (row_total > frame_max) frame_max <= row_total;
                            if (band_end) begin
                                band_acc[band] <= (q_next >= QUAL_MIN);
                                qual_cnt       <= '0;
                                rib            <= '0;
                                band <= (band == LAST_BAND) ? '0 : band + BW'(1);
                            end else begin
                                qual_cnt <= q_next;
                                rib      <= rib + RBW'(1);
                            end
                        end
                        if (frame_end) begin
                            state   <= ST_DECIDE;
                            x_ready <= 1'b0;
                        end
                    end
                end
                ST_DECIDE: begin
                    state           <= ST_RUN;
                    x_ready         <= 1'b1;
                    band_mask       <= band_acc;
                    stripe_count    <= frame_max;
                    detection_valid <= 1'b1;
                    band_acc        <= '0;
                    frame_max       <= '0;
                    // Toggle only after a streak of disagreeing frames.
                    if (pos != crossing_detected) begin
                        if (streak == HYST_LAST) begin
                            crossing_detected <= ~crossing_detected;
                            streak            <= '0;
                        end else begin
                            streak <= streak + HW'(1);
                        end
                    end else begin
                        streak <= '0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_zebra_stripe_analyzer.sv
// Self-checking bench for zebra_stripe_analyzer: scoreboard of per-frame
// expectations from a software model, popped on each detection pulse.
module tb_zebra_stripe_analyzer;

    logic       clk;
    logic       rst_n;
    logic       x_valid;
    logic       x_ready;
    logic [7:0] x_data;
    logic [7:0] cfg_thresh;
    logic       crossing_detected;
    logic       detection_valid;
    logic [7:0] stripe_count;
    logic [1:0] band_mask;

    zebra_stripe_analyzer #(
        .IMG_WIDTH    (32),
        .IMG_HEIGHT   (8),
        .W            (8),
        .NUM_BANDS    (2),
        .MIN_STRIPE_W (2),
        .MAX_STRIPE_W (6),
        .MIN_STRIPES  (3),
        .ROW_QUAL_MIN (3),
        .MIN_BANDS    (2),
        .HYST_FRAMES  (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .x_valid           (x_valid),
        .x_ready           (x_ready),
        .x_data            (x_data),
        .cfg_thresh        (cfg_thresh),
        .crossing_detected (crossing_detected),
        .detection_valid   (detection_valid),
        .stripe_count      (stripe_count),
        .band_mask         (band_mask)
    );

    typedef struct {
        logic [7:0] sc;
        logic [1:0] bm;
        logic       cd;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   ready_low = 0;
    bit   seen_ready = 0;
    bit   prev_dv    = 0;
    bit   m_cross    = 0;
    int   m_streak   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Kinds: 0 = 4x(4 white, 4 black), 1 = all white,
    // 2 = two interior stripes plus edge run at 29-31,
    // 3 = pattern 0 in top band, black bottom band.
    function automatic logic [7:0] pix(input int kind, input int r,
                                       input int c, input logic [7:0] wv);
        case (kind)
            0: return ((c % 8) < 4) ? wv : 8'h00;
            1: return 8'hFF;
            2: return (c < 4 || (c >= 8 && c < 12) || c >= 29)
                      ? 8'hFF : 8'h00;
            3: return (r < 4 && (c % 8) < 4) ? wv : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model(input int kind, input logic [7:0] wv,
                         output exp_t e);
        int q;
        int run;
        int s;
        bit w;
        bit pos;
        e.sc = 0;
        e.bm = 0;
        for (int b = 0; b < 2; b++) begin
            q = 0;
            for (int rr = 0; rr < 4; rr++) begin
                run = 0;
                s   = 0;
                for (int c = 0; c < 32; c++) begin
                    w = (pix(kind, b * 4 + rr, c, wv) >= 8'd128);
                    if (w) run++;
                    if (!w || c == 31) begin
                        if (run >= 2 && run <= 6) s++;
                        run = 0;
                    end
                end
                if (s > int'(e.sc)) e.sc = 8'(s);
                if (s >= 3) q++;
            end
            e.bm[b] = (q >= 3);
        end
        pos = ($countones(e.bm) >= 2);
        if (pos != m_cross) begin
            m_streak++;
            if (m_streak == 2) begin
                m_cross  = !m_cross;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
        e.cd = m_cross;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!x_ready && seen_ready) ready_low++;
            if (x_ready) seen_ready = 1;
            if (detection_valid) begin
                chk("dv_pulse", 32'(prev_dv), 0);
                if (sb.size() == 0) begin
                    chk("dv_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("stripe_count", 32'(stripe_count), 32'(e.sc));
                    chk("band_mask", 32'(band_mask), 32'(e.bm));
                    chk("crossing", 32'(crossing_detected), 32'(e.cd));
                end
            end
            prev_dv = detection_valid;
        end else begin
            seen_ready = 0;
            prev_dv    = 0;
        end
    end

    task automatic send(input logic [7:0] d, input int gap,
                        input logic [7:0] thr);
        int n;
        if (gap > 0) begin
            @(negedge clk);
            x_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk);
        x_data     = d;
        x_valid    = 1'b1;
        cfg_thresh = thr;
        n = 0;
        while (!x_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) chk("ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic drive_frame(input int kind, input logic [7:0] wv,
                               input bit gaps, input bit midthr,
                               input int npix);
        exp_t e;
        int   gap;
        int   p;
        logic [7:0] thr;
        if (npix == 256) begin
            model(kind, wv, e);
            sb.push_back(e);
        end
        p = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                if (p < npix) begin
                    gap = gaps ? (($urandom_range(0, 3) == 0)
                                  ? int'($urandom_range(1, 3)) : 0) : 0;
                    thr = (midthr && p > 0) ? 8'd0 : 8'd128;
                    send(pix(kind, r, c, wv), gap, thr);
                    p++;
                end
            end
        end
        @(negedge clk);
        x_valid    = 1'b0;
        cfg_thresh = 8'd128;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("dv_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        x_valid    = 1'b0;
        x_data     = 8'h00;
        cfg_thresh = 8'd128;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(x_ready), 0);
        chk("rst_cross", 32'(crossing_detected), 0);
        chk("rst_dv", 32'(detection_valid), 0);
        chk("rst_sc", 32'(stripe_count), 0);
        chk("rst_bm", 32'(band_mask), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(x_ready), 0);
        @(negedge clk);
        chk("ready_after_edge", 32'(x_ready), 1);

        drive_frame(0, 8'hFF, 0, 0, 256); wait_done();
        drive_frame(0, 8'hFF, 0, 0, 256); wait_done();
        drive_frame(1, 8'hFF, 0, 0, 256); wait_done();
        drive_frame(1, 8'hFF, 0, 0, 256); wait_done();
        drive_frame(2, 8'hFF, 0, 0, 256); wait_done();
        drive_frame(1, 8'hFF, 0, 0, 256); wait_done();
        drive_frame(0, 8'd128, 0, 1, 256); wait_done();
        drive_frame(3, 8'hFF, 0, 0, 256); wait_done();

        for (int f = 0; f < 2; f++) begin
            ready_low = 0;
            drive_frame(0, 8'hFF, 1, 0, 256);
            wait_done();
            chk("ready_low_once", 32'(ready_low), 1);
        end

        drive_frame(0, 8'hFF, 0, 0, 5 * 32 + 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(x_ready), 0);
        chk("mid_rst_cross", 32'(crossing_detected), 0);
        chk("mid_rst_sc", 32'(stripe_count), 0);
        chk("mid_rst_bm", 32'(band_mask), 0);
        m_cross  = 0;
        m_streak = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_frame(0, 8'hFF, 0, 0, 256); wait_done();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
